// File: rtl/vedic_seq_mult_ctrl.sv
// rtl/vedic_seq_mult_ctrl.sv - sequential WIDTHxWIDTH multiplier reusing one 2x2 vedic core
module vedic_seq_mult_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   c,
  output logic                 busy
);

  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   ra, rb;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [IW-1:0]      i, j;
  logic [1:0]         da, db;
  logic [3:0]         pp;
  logic               carry;
  logic [IW+1:0]      sh;

  // 2x2 vedic core: vertical/crosswise terms, carry folded into bits 2..3
  always_comb begin
    da       = 2'(ra >> {i, 1'b0});
    db       = 2'(rb >> {j, 1'b0});
    carry    = da[1] & db[0] & da[0] & db[1];
    pp       = {da[1] & db[1] & carry,
                (da[1] & db[1]) ^ carry,
                (da[1] & db[0]) ^ (da[0] & db[1]),
                da[0] & db[0]};
    sh       = ({2'b00, i} + {2'b00, j}) << 1;
    acc_next = acc + ((2*WIDTH)'(pp) << sh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
      i     <= '0;
      j     <= '0;
      c     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra    <= a;
            rb    <= b;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (j == LAST) begin
            j <= '0;
            if (i == LAST) begin
              c     <= acc_next;
              state <= DONE;
            end else begin
              i <= i + IW'(1);
            end
          end else begin
            j <= j + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_vedic_seq_mult_ctrl.sv
// tb/tb_vedic_seq_mult_ctrl.sv - directed checks of vedic_seq_mult_ctrl at WIDTH 16, 2 and 8
module tb_vedic_seq_mult_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        iv16 = 0, ir16, ov16, or16 = 0, busy16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] c16;
  logic        iv2 = 0, ir2, ov2, or2 = 0, busy2;
  logic [1:0]  a2 = 0, b2 = 0;
  logic [3:0]  c2;
  logic        iv8 = 0, ir8, ov8, or8 = 0, busy8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] c8;

  vedic_seq_mult_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .c(c16), .busy(busy16));
  vedic_seq_mult_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(or2), .c(c2), .busy(busy2));
  vedic_seq_mult_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .c(c8), .busy(busy8));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mul16(input logic [15:0] ta, input logic [15:0] tb,
                       input logic [31:0] exp, input int hold, input bit garble);
    int cnt;
    int bc;
    @(negedge clk);
    a16 = ta; b16 = tb; iv16 = 1;
    @(posedge clk); #1;
    chk("w16_busy_accept", busy16, 1);
    chk("w16_in_ready_run", ir16, 0);
    @(negedge clk);
    iv16 = 0;
    if (garble) begin a16 = 16'hFFFF; b16 = 16'hFFFF; end
    cnt = 0; bc = 1;
    while (!ov16 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      if (busy16) bc++;
    end
    chk("w16_latency", cnt, 64);
    chk("w16_busy_cycles", bc, 64);
    chk("w16_product", c16, exp);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      iv16 = 1;
      @(posedge clk); #1;
      chk("w16_hold_c", c16, exp);
      chk("w16_hold_valid", ov16, 1);
      chk("w16_hold_in_ready", ir16, 0);
    end
    @(negedge clk);
    iv16 = 0; or16 = 1;
    @(posedge clk); #1;
    chk("w16_release_valid", ov16, 0);
    chk("w16_release_in_ready", ir16, 1);
    chk("w16_c_kept", c16, exp);
    @(negedge clk);
    or16 = 0;
  endtask

  task automatic mul2(input logic [1:0] ta, input logic [1:0] tb);
    int cnt;
    @(negedge clk);
    a2 = ta; b2 = tb; iv2 = 1;
    @(posedge clk); #1;
    @(negedge clk);
    iv2 = 0;
    cnt = 0;
    while (!ov2 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("w2_latency", cnt, 1);
    chk("w2_product", c2, 4'(ta * tb));
    @(negedge clk);
    or2 = 1;
    @(posedge clk); #1;
    @(negedge clk);
    or2 = 0;
  endtask

  task automatic mul8(input logic [7:0] ta, input logic [7:0] tb);
    int cnt;
    logic [15:0] exp;
    exp = 16'(ta) * 16'(tb);
    @(negedge clk);
    a8 = ta; b8 = tb; iv8 = 1;
    @(posedge clk); #1;
    @(negedge clk);
    iv8 = 0;
    cnt = 0;
    while (!ov8 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("w8_latency", cnt, 16);
    chk("w8_product", c8, exp);
    @(negedge clk);
    or8 = 1;
    @(posedge clk); #1;
    @(negedge clk);
    or8 = 0;
  endtask

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", ir16, 1);
    chk("rst_out_valid", ov16, 0);
    chk("rst_busy", busy16, 0);
    chk("rst_c", c16, 0);
    chk("rst_c_w8", c8, 0);
    @(negedge clk);
    rst = 0;

    mul16(16'd3, 16'd3, 32'h0000_0009, 0, 0);
    mul16(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0, 0);
    mul16(16'h1234, 16'h0000, 32'h0000_0000, 0, 0);
    mul16(16'h00FF, 16'h0101, 32'h0000_FFFF, 10, 0);
    mul16(16'hABCD, 16'h1234, 32'h0C37_4FA4, 0, 1);

    // abort at RUN cycle 20
    @(negedge clk);
    a16 = 16'h5555; b16 = 16'h3333; iv16 = 1;
    @(posedge clk); #1;
    @(negedge clk);
    iv16 = 0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("abort_in_ready", ir16, 1);
    chk("abort_busy", busy16, 0);
    chk("abort_out_valid", ov16, 0);
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (ov16 || busy16) seen++;
    end
    chk("abort_no_result", seen, 0);
    mul16(16'd7, 16'd6, 32'd42, 0, 0);

    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        mul2(2'(x), 2'(y));

    mul8(8'hFF, 8'hFF);
    mul8(8'h00, 8'hA5);
    for (int k = 0; k < 1000; k++)
      mul8(8'($urandom), 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
